// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multi-cycle MIPS main control FSM and the ALU
// control block:
//   - opcode values of the supported instruction classes (IR[31:26])
//   - state encodings of the main control FSM
//   - ALUOp / ALUSrcB / PCSource field encodings
//   - ctrl_t, the packed control vector produced by the state decoder
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

    // Instruction opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALUOp encodings, consumed by ALU control
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Main control FSM state codes; code 15 is unused and recovers to ST_RST
    typedef enum logic [3:0] {
        ST_RST       = 4'd0,
        ST_FETCH     = 4'd1,
        ST_FETCH_WB  = 4'd2,
        ST_DECODE    = 4'd3,
        ST_MEM_ADR   = 4'd4,
        ST_MEM_RD    = 4'd5,
        ST_MEM_RD_WB = 4'd6,
        ST_MEM_WR    = 4'd7,
        ST_R_EXE     = 4'd8,
        ST_R_WB      = 4'd9,
        ST_BR_EXE    = 4'd10,
        ST_J_EXE     = 4'd11,
        ST_ADDI_EXE  = 4'd12,
        ST_ADDI_WB   = 4'd13,
        ST_HALT      = 4'd14
    } state_t;

    // Control vector decoded from the state register
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       retire;
    } ctrl_t;

    // True for opcodes the control FSM knows how to execute
    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_LW)  || (op == OP_SW)  || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_J)   || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// -----------------------------------------------------------------------------
// mc_ctrl_decode
// Pure combinational decoder from the main control FSM state to the datapath
// control vector. Every field not explicitly driven in a state is 0.
// Ports:
//   state  in   state_t  current FSM state (registered in the top)
//   ctrl   out  ctrl_t   datapath control vector for that state
// -----------------------------------------------------------------------------
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b0;
            end
            ST_FETCH_WB: begin
                // ReadData from the FETCH read is valid now; PC <= PC + 4
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
            end
            ST_DECODE: begin
                // Speculative branch target into ALUOut
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SL2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEM_ADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEM_RD_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.retire     = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                ctrl.retire    = 1'b1;
            end
            ST_R_EXE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.retire     = 1'b1;
            end
            ST_BR_EXE: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.retire        = 1'b1;
            end
            ST_J_EXE: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.retire    = 1'b1;
            end
            ST_ADDI_EXE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b0;
                ctrl.retire    = 1'b1;
            end
            default: ctrl = '0;  // RST, HALT and unused codes drive nothing
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Main control FSM of the multi-cycle MIPS datapath. Drives the synchronous
// word-addressed Memory strobes and all datapath mux/enable controls. Memory
// reads are registered, so fetch and load each have a capture state.
// Parameters:
//   STATE_W   width of dbg_state
//   HALT_ILL  1: illegal opcode enters sticky HALT; 0: treated as NOP
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   Op                      IR[31:26], used for next-state in DECODE/MEM_ADR
//   PCWrite, PCWriteCond    PC load (unconditional / qualified by Zero)
//   IorD                    Memory address mux (0=PC, 1=ALUOut)
//   MemRead, MemWrite       Memory strobes
//   IRWrite                 IR load from ReadData
//   MemtoReg, RegDst        regfile write data / address select
//   RegWrite                regfile write enable
//   ALUSrcA, ALUSrcB, ALUOp ALU operand selects and operation class
//   PCSource                next-PC source select
//   retire                  pulse in the last state of each instruction
//   illegal_op              sticky flag, set on entry to HALT
//   dbg_state               current state code
// -----------------------------------------------------------------------------
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W  = 4,
    parameter bit HALT_ILL = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         Op,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               retire,
    output logic               illegal_op,
    output logic [STATE_W-1:0] dbg_state
);

    state_t state;
    state_t next_state;
    ctrl_t  ctrl;
    logic   nop_retire;

    // Next-state logic
    always_comb begin
        next_state = ST_RST;
        nop_retire = 1'b0;
        case (state)
            ST_RST:      next_state = ST_FETCH;
            ST_FETCH:    next_state = ST_FETCH_WB;
            ST_FETCH_WB: next_state = ST_DECODE;
            ST_DECODE: begin
                if (Op == OP_LW || Op == OP_SW) begin
                    next_state = ST_MEM_ADR;
                end else if (Op == OP_RTYPE) begin
                    next_state = ST_R_EXE;
                end else if (Op == OP_BEQ) begin
                    next_state = ST_BR_EXE;
                end else if (Op == OP_J) begin
                    next_state = ST_J_EXE;
                end else if (Op == OP_ADDI) begin
                    next_state = ST_ADDI_EXE;
                end else if (HALT_ILL) begin
                    next_state = ST_HALT;
                end else begin
                    // Illegal opcode treated as a NOP that retires in DECODE
                    next_state = ST_FETCH;
                    nop_retire = 1'b1;
                end
            end
            // IR is not written after FETCH_WB, so Op is still the current
            // instruction's opcode here.
            ST_MEM_ADR:   next_state = (Op == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:    next_state = ST_MEM_RD_WB;
            ST_MEM_RD_WB: next_state = ST_FETCH;
            ST_MEM_WR:    next_state = ST_FETCH;
            ST_R_EXE:     next_state = ST_R_WB;
            ST_R_WB:      next_state = ST_FETCH;
            ST_BR_EXE:    next_state = ST_FETCH;
            ST_J_EXE:     next_state = ST_FETCH;
            ST_ADDI_EXE:  next_state = ST_ADDI_WB;
            ST_ADDI_WB:   next_state = ST_FETCH;
            ST_HALT:      next_state = ST_HALT;
            default:      next_state = ST_RST;
        endcase
    end

    // State register and sticky illegal-opcode flag. Reset is asynchronous so
    // a write strobe in flight drops before the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RST;
            illegal_op <= 1'b0;
        end else begin
            state      <= next_state;
            illegal_op <= illegal_op | (next_state == ST_HALT);
        end
    end

    mc_ctrl_decode u_decode (
        .state (state),
        .ctrl  (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    // The NOP path is the only Op-dependent output term; it only exists when
    // illegal opcodes do not halt.
    assign retire      = ctrl.retire | nop_retire;
    assign dbg_state   = STATE_W'(state);

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Directed bench for the multi-cycle MIPS main control FSM. Each step samples
// the state code and the full control vector on the falling clock edge and
// compares them against hand-written expectations.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] Op;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       retire, illegal_op;
    logic [3:0] dbg_state;

    int total = 0;
    int bad   = 0;

    multicycle_control #(
        .STATE_W  (4),
        .HALT_ILL (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Op          (Op),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .retire      (retire),
        .illegal_op  (illegal_op),
        .dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed control vector, same field order as v() below
    logic [17:0] obs;
    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                  PCSource, retire, illegal_op};

    function automatic logic [17:0] v(
        input logic pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca,
        input logic [1:0] srcb, aop, pcsrc,
        input logic ret, ill);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, srca,
                srcb, aop, pcsrc, ret, ill};
    endfunction

    //                               pcw pcwc iord mr mw irw m2r rd rw sa srcb   aop    pcsrc  ret ill
    localparam logic [17:0] E_ZERO  = v(0, 0,  0,  0, 0, 0,  0,  0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    localparam logic [17:0] E_F     = v(0, 0,  0,  1, 0, 0,  0,  0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    localparam logic [17:0] E_FWB   = v(1, 0,  0,  0, 0, 1,  0,  0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0);
    localparam logic [17:0] E_DEC   = v(0, 0,  0,  0, 0, 0,  0,  0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0);
    localparam logic [17:0] E_MADR  = v(0, 0,  0,  0, 0, 0,  0,  0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0);
    localparam logic [17:0] E_MRD   = v(0, 0,  1,  1, 0, 0,  0,  0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    localparam logic [17:0] E_MRWB  = v(0, 0,  0,  0, 0, 0,  1,  0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    localparam logic [17:0] E_MWR   = v(0, 0,  1,  0, 1, 0,  0,  0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    localparam logic [17:0] E_REXE  = v(0, 0,  0,  0, 0, 0,  0,  0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0);
    localparam logic [17:0] E_RWB   = v(0, 0,  0,  0, 0, 0,  0,  1, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    localparam logic [17:0] E_BR    = v(0, 1,  0,  0, 0, 0,  0,  0, 0, 1, 2'b00, 2'b01, 2'b01, 1, 0);
    localparam logic [17:0] E_J     = v(1, 0,  0,  0, 0, 0,  0,  0, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0);
    localparam logic [17:0] E_AEXE  = v(0, 0,  0,  0, 0, 0,  0,  0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0);
    localparam logic [17:0] E_AWB   = v(0, 0,  0,  0, 0, 0,  0,  0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    localparam logic [17:0] E_HALT  = v(0, 0,  0,  0, 0, 0,  0,  0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1);

    // Compare current outputs against expectations without advancing time
    task automatic check(input string tag, input logic [3:0] es, input logic [17:0] ec);
        total++;
        assert (dbg_state === es) else begin
            bad++;
            $error("FAIL %s state: observed=%0d expected=%0d", tag, dbg_state, es);
        end
        total++;
        assert (obs === ec) else begin
            bad++;
            $error("FAIL %s ctrl: observed=%b expected=%b", tag, obs, ec);
        end
    endtask

    // Advance to the next falling edge, then check
    task automatic step(input string tag, input logic [3:0] es, input logic [17:0] ec);
        @(negedge clk);
        check(tag, es, ec);
    endtask

    task automatic fetch_decode(input string tag, input logic [5:0] op);
        Op = op;
        step({tag, "_fetch"},  4'd1, E_F);
        step({tag, "_fetchwb"}, 4'd2, E_FWB);
        step({tag, "_decode"}, 4'd3, E_DEC);
    endtask

    // Watchdog: the directed sequence is a few hundred cycles at most
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst_n = 1'b0;
        Op    = 6'b000000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset", 4'd0, E_ZERO);
        rst_n = 1'b1;

        // lw: 6 cycles
        fetch_decode("lw", 6'b100011);
        step("lw_madr",  4'd4, E_MADR);
        step("lw_mrd",   4'd5, E_MRD);
        step("lw_mrdwb", 4'd6, E_MRWB);

        // sw: 5 cycles
        fetch_decode("sw", 6'b101011);
        step("sw_madr", 4'd4, E_MADR);
        step("sw_mwr",  4'd7, E_MWR);

        // R-type: 5 cycles
        fetch_decode("r", 6'b000000);
        step("r_exe", 4'd8, E_REXE);
        step("r_wb",  4'd9, E_RWB);

        // beq: 4 cycles
        fetch_decode("beq", 6'b000100);
        step("beq_exe", 4'd10, E_BR);

        // j: 4 cycles
        fetch_decode("j", 6'b000010);
        step("j_exe", 4'd11, E_J);

        // addi: 5 cycles
        fetch_decode("addi", 6'b001000);
        step("addi_exe", 4'd12, E_AEXE);
        step("addi_wb",  4'd13, E_AWB);

        // Illegal opcode: sticky HALT
        fetch_decode("ill", 6'b111111);
        step("ill_halt", 4'd14, E_HALT);
        Op = 6'b100011;  // a legal Op must not release HALT
        for (int i = 0; i < 20; i++) step("ill_hold", 4'd14, E_HALT);

        // Asynchronous reset pulse clears HALT and illegal_op immediately
        rst_n = 1'b0;
        #1;
        check("halt_rst_async", 4'd0, E_ZERO);
        @(negedge clk);
        check("halt_rst_held", 4'd0, E_ZERO);
        rst_n = 1'b1;
        step("halt_rst_fetch", 4'd1, E_F);
        step("halt_rst_fetchwb", 4'd2, E_FWB);
        step("halt_rst_decode", 4'd3, E_DEC);
        step("halt_rst_lw_madr", 4'd4, E_MADR);
        step("halt_rst_lw_mrd", 4'd5, E_MRD);
        step("halt_rst_lw_mrdwb", 4'd6, E_MRWB);

        // Reset asserted mid MEM_WR: MemWrite drops before the next edge
        fetch_decode("sw2", 6'b101011);
        step("sw2_madr", 4'd4, E_MADR);
        step("sw2_mwr",  4'd7, E_MWR);
        #2;
        rst_n = 1'b0;
        #1;
        check("mwr_rst_async", 4'd0, E_ZERO);
        total++;
        assert (MemWrite === 1'b0) else begin
            bad++;
            $error("FAIL mwr_rst_memwrite: observed=%b expected=0", MemWrite);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step("mwr_rst_fetch", 4'd1, E_F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
